// File: rtl/exmem_stage_skid.sv
// exmem_stage_skid: EX/MEM pipeline register with a valid/ready handshake
// and a 2-entry skid buffer. EX is never stalled combinationally from MEM.
// in_ready depends only on registered state.
//
// Ports:
//   clk, reset (async, active low), flush (sync, kills held entries)
//   in_valid/in_ready + in_* payload   : beat offered by EX
//   out_valid/out_ready + out_* payload : beat held for MEM (main entry)
//   mem_size/mem_rw/mem_se/mem_enable/load_instr/rf_enable
//                                       : out_ctrl fields, zero when no beat
//   occupancy                           : number of held entries (0..2)
//
// CTRL_W must be >= 11 so that all decoded control bits exist.
module exmem_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 22,
  parameter int RD_W   = 5,
  parameter int PC_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_pa,
  input  logic [DATA_W-1:0] in_alu,
  input  logic              in_flag,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [PC_W-1:0]   in_pc8,
  input  logic              in_r31,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_pa,
  output logic [DATA_W-1:0] out_alu,
  output logic              out_flag,
  output logic [RD_W-1:0]   out_rd,
  output logic [PC_W-1:0]   out_pc8,
  output logic              out_r31,
  output logic [1:0]        mem_size,
  output logic              mem_rw,
  output logic              mem_se,
  output logic              mem_enable,
  output logic              load_instr,
  output logic              rf_enable,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] pa;
    logic [DATA_W-1:0] alu;
    logic              flag;
    logic [RD_W-1:0]   rd;
    logic [PC_W-1:0]   pc8;
    logic              r31;
  } beat_t;

  // Encoding equals the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  beat_t  m_q, s_q, in_beat;
  logic   m_valid, s_valid;
  logic   acc, pop;
  logic   ld_m_in, ld_s_in, ld_m_s;

  assign in_beat = '{ctrl: in_ctrl, pa: in_pa, alu: in_alu, flag: in_flag,
                     rd: in_rd, pc8: in_pc8, r31: in_r31};

  assign m_valid  = (state == ONE) || (state == FULL);
  assign s_valid  = (state == FULL);
  assign in_ready = !s_valid;
  assign acc      = in_valid && in_ready;
  assign pop      = m_valid && out_ready;

  // Next state and payload steering. Flush only overrides the state; any
  // payload loaded alongside it belongs to an invalid entry and is ignored.
  always_comb begin
    state_nxt = state;
    ld_m_in   = 1'b0;
    ld_s_in   = 1'b0;
    ld_m_s    = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        state_nxt = ONE;
        ld_m_in   = 1'b1;
      end
      ONE: begin
        if (acc && !pop) begin
          state_nxt = FULL;
          ld_s_in   = 1'b1;
        end else if (acc && pop) begin
          ld_m_in   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (pop) begin
        state_nxt = ONE;
        ld_m_s    = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (ld_m_in)     m_q <= in_beat;
      else if (ld_m_s) m_q <= s_q;
      if (ld_s_in)     s_q <= in_beat;
    end
  end

  assign out_valid = m_valid;
  assign out_ctrl  = m_q.ctrl;
  assign out_pa    = m_q.pa;
  assign out_alu   = m_q.alu;
  assign out_flag  = m_q.flag;
  assign out_rd    = m_q.rd;
  assign out_pc8   = m_q.pc8;
  assign out_r31   = m_q.r31;

  // A bubble must never enable memory or a register write.
  assign mem_size   = m_valid ? m_q.ctrl[6:5] : 2'b00;
  assign mem_rw     = m_valid & m_q.ctrl[4];
  assign mem_se     = m_valid & m_q.ctrl[3];
  assign mem_enable = m_valid & m_q.ctrl[0];
  assign load_instr = m_valid & m_q.ctrl[10];
  assign rf_enable  = m_valid & m_q.ctrl[9];

  assign occupancy  = {s_valid, m_valid & ~s_valid};

endmodule

// File: doc/exmem_stage_skid.md
Name: exmem_stage_skid

Overview:
- Parametrised successor to the EX/MEM pipeline register, sitting between the execute and memory stages.
- Carries the full control word and EX results to MEM, and decodes the memory/register-file control fields.
- Adds a valid/ready handshake with a 2-entry skid buffer, so MEM back-pressure (multi-cycle memory) does not need a combinational stall path into EX.
- Adds a synchronous flush that converts all held entries to bubbles.

Parameters:
- DATA_W, 32, width of PA and ALU result fields.
- CTRL_W, 22, width of the control word; must be >= 11.
- RD_W, 5, destination register index width.
- PC_W, 9, width of the PC+8 field.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EX offers a beat
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  control word from EX
- in_pa  in  DATA_W  EX PA operand
- in_alu  in  DATA_W  EX ALU result
- in_flag  in  1  EX condition flag
- in_rd  in  RD_W  destination register
- in_pc8  in  PC_W  PC+8
- in_r31  in  1  link-to-R31 select
- out_valid  out  1  MEM-side beat valid
- out_ready  in  1  MEM consumes the beat
- out_ctrl  out  CTRL_W  held control word
- out_pa, out_alu  out  DATA_W  held operands
- out_flag  out  1  held flag
- out_rd  out  RD_W  held destination register
- out_pc8  out  PC_W  held PC+8
- out_r31  out  1  held R31 select
- mem_size  out  2  out_ctrl[6:5], gated
- mem_rw  out  1  out_ctrl[4], gated
- mem_se  out  1  out_ctrl[3], gated
- mem_enable  out  1  out_ctrl[0], gated
- load_instr  out  1  out_ctrl[10], gated
- rf_enable  out  1  out_ctrl[9], gated
- occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Storage: a main entry M, which drives all out_* ports, plus a skid entry S. Each entry has its own valid bit.
- States, by occupancy:
  - EMPTY: no entries valid.
  - ONE: M valid.
  - FULL: M and S valid.
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !S.valid. It depends only on registered state; there is no combinational path from out_ready.
- out_valid = M.valid.
- Transitions (flush = 0):
  - EMPTY, acc → ONE; input loads M.
  - ONE, acc & !pop → FULL; input loads S.
  - ONE, acc & pop → ONE; input loads M.
  - ONE, !acc & pop → EMPTY.
  - FULL, pop → ONE; S moves to M, S invalidated. acc is impossible because in_ready = 0.
  - FULL, !pop → FULL; everything holds.
- Latency: one cycle from acceptance to out_valid when the stage is empty. Throughput is one beat per cycle while out_ready is held high.
- Ordering: strict FIFO; the S contents always leave after M.
- Flush (synchronous, highest priority):
  - Next state is EMPTY.
  - A beat accepted in the same cycle is discarded.
  - A pop in the same cycle still counts as consumed by MEM.
- Decoded outputs (mem_*, load_instr, rf_enable) equal their out_ctrl bit fields when out_valid = 1, and are 0 otherwise. Invalid entries never enable memory or register-file writes.
- Payload registers of an invalid entry hold their old values and are don't-care. Only valid bits and the decoded outputs are architecturally defined.
- Reset (asynchronous, reset = 0):
  - Both valid bits = 0; occupancy = 0; in_ready = 1.
  - All payload registers and out_* = 0; all decoded outputs = 0.
  - Reset mid-operation drops any held beats immediately, without waiting for a clock edge.
- Width rules: fields are copied bit-exact with no extension or truncation. in_pc8 is PC_W bits end to end.

Test Plan:
1. Reset held low, then released: occupancy = 0, out_valid = 0, in_ready = 1, all outputs 0, while in_valid toggles during reset.
2. Streaming with out_ready = 1: send three beats with in_alu = 0x11, 0x22, 0x33 and in_ctrl having bit 0 = 1. out_alu shows 0x11, 0x22, 0x33 on the three cycles after acceptance, mem_enable = 1 on each, occupancy stays at 1.
3. Back-pressure: with out_ready = 0, send beats A (in_rd = 3) and B (in_rd = 7). After two edges occupancy = 2 and in_ready = 0, and out_rd = 3 holds. Raise out_ready: out_rd goes 3 then 7, and in_ready returns to 1 after the first pop.
4. Flush in FULL with in_valid = 1: the next cycle shows occupancy = 0, out_valid = 0, mem_enable = 0, rf_enable = 0, and the incoming beat never appears.
5. Control decode: in_ctrl = 0x00067D, popped immediately. Outputs are mem_size = 2'b11, mem_rw = 1, mem_se = 1, mem_enable = 1, rf_enable = 1, load_instr = 1. Follow with a bubble cycle: all decoded outputs = 0.
6. Asynchronous reset asserted mid-cycle in FULL: occupancy = 0 and out_valid = 0 before the next clock edge.
